slave_mem_burst: RTL and testbench
==================================

Name: slave_mem_burst

Overview:
- Parametrised serial-bus memory slave; next generation of the fixed 2K×8 slave.
- Sits behind the bus arbiter on the same single-bit serial bus (AD_SEL / B_* signals) and mirrors written data on the local S_DOUT port.
- Adds:
  - configurable data width, memory depth and slave ID;
  - ID match with silent ignore on mismatch;
  - multi-beat bursts with address auto-increment and wrap.

Parameters:
DATA_W, 8, bits per data beat.
MEM_AW, 11, memory address bits; DEPTH = 2**MEM_AW words.
ID_W, 2, slave-ID field width in the address frame.
LEN_W, 3, burst-length field width; beats = LEN+1 (1..2**LEN_W).
SLAVE_ID, 2'b00, ID this instance responds to.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous reset, active-high.
AD_SEL  in  1  slave selected by arbiter; low = release/abort.
B_RW  in  1  1 = write, 0 = read; sampled on the last address-bit cycle.
B_BUS_OUT  in  1  serial master->slave data, LSB first.
B_BUS_IN  out  1  serial slave->master read data, LSB first.
B_ACK  out  1  acknowledge pulse.
B_SBSY  out  1  slave busy.
B_READY  out  1  slave ready (registered AD_SEL).
S_DVALID  out  1  one-cycle pulse: S_DOUT holds the newly written word.
S_DOUT  out  DATA_W  last written word.

Behaviour:
- Reset (RST=1 at CLK edge):
  - state=IDLE; all counters 0.
  - B_ACK, B_SBSY, B_READY, B_BUS_IN, S_DVALID = 0; S_DOUT = 0.
  - Memory array is not reset.
  - Reset mid-transfer aborts at once; the partial beat is not written.
- Outputs: all registered except B_BUS_IN (Moore, from registered bit counter and memory read).
- B_READY <= AD_SEL every non-reset cycle. B_SBSY = 1 in every state except IDLE and IGNORE.
- Address frame: A_W = ID_W + MEM_AW + LEN_W bits, LSB first.
  - Order: ID, then ADDR, then LEN.
- States:
  - IDLE: AD_SEL=1 -> ADDR.
  - ADDR: samples B_BUS_OUT each cycle, bit i in the i-th ADDR cycle.
    - After A_W bits, B_RW is captured in the same cycle as the last bit.
    - ID==SLAVE_ID -> ACKA; otherwise -> IGNORE.
  - IGNORE: all bus outputs 0; -> IDLE when AD_SEL=0.
  - ACKA: B_ACK=1 for exactly 2 cycles.
    - Then -> WRITE if RW=1, READ if RW=0.
    - Beat counter = LEN; word pointer = ADDR.
  - WRITE: samples DATA_W bits into a shift register, one per cycle.
    - On the last bit, writes mem[ptr] -> ACKW.
  - ACKW: B_ACK=1 for 2 cycles.
    - S_DVALID=1 with S_DOUT=written word in the first ACKW cycle.
    - ptr <= ptr+1 mod DEPTH.
    - Beat counter 0 -> IDLE; otherwise decrement -> WRITE.
  - READ: B_BUS_IN = mem[ptr][i] in the i-th cycle.
    - After DATA_W cycles: ptr+1 mod DEPTH.
    - Beats remaining -> next READ beat with no gap cycle; otherwise -> IDLE.
- AD_SEL=0 in any state other than IDLE/IGNORE: -> IDLE next cycle.
  - The partial beat is discarded and there is no ACK.
  - Completed beats stay written.
- Pointer wrap: ptr=DEPTH-1 increments to 0 within a burst.
- Back-to-back: IDLE with AD_SEL still high re-enters ADDR next cycle.
- Minimum IDLE dwell between transactions: 1 cycle.
- Widths:
  - Bit counters: $clog2(max(A_W, DATA_W)) bits.
  - Beat counter: LEN_W bits.
  - ptr: MEM_AW bits, unsigned, natural wrap.

Decomposition:
- Package slave_pkg:
  - state enum (IDLE, ADDR, IGNORE, ACKA, WRITE, ACKW, READ);
  - ACK_CYCLES = 2;
  - a helper function for the A_W width.
- Reuse the existing counter module (rst/incr/count) for the bit counter; no other sub-module.
- Memory is an inferred array in this module.

Test Plan (DATA_W=8, MEM_AW=11, ID_W=2, LEN_W=3, SLAVE_ID=2'b10):
1. Single write: ID=2, ADDR=0x005, LEN=0, RW=1, data 0xA5 -> 2 ACK cycles after the address; after the data, 2 ACK cycles; S_DVALID pulse with S_DOUT=0xA5; read-back of 0x005 returns bits 1,0,1,0,0,1,0,1 on B_BUS_IN.
2. Burst wrap: write LEN=2 at ADDR=0x7FF with 0x11, 0x22, 0x33 -> mem[0x7FF]=0x11, mem[0x000]=0x22, mem[0x001]=0x33; 3 S_DVALID pulses. Then a burst read LEN=2 from 0x7FF -> 24 contiguous bits, LSB first, with no gap cycles.
3. ID mismatch: ID=1 -> B_ACK stays 0 and B_SBSY=0 after the address phase; memory unchanged; IDLE after AD_SEL drops.
4. Abort: AD_SEL drops after 4 data bits of a write to 0x010 holding 0x5A -> no ACK, no S_DVALID, mem[0x010] stays 0x5A, state IDLE next cycle.
5. Reset mid-read: RST=1 during beat 2 of a read -> all outputs 0 on the next cycle; a new transaction after reset works normally.
6. Back-to-back: two single writes with 1 IDLE cycle between -> both ACKed; S_DVALID pulses carry the correct data.

Source files
------------

// File: rtl/slave_pkg.sv
// Shared types and sizing helpers for the burst-capable serial memory slave.
package slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        IGNORE,
        ACKA,
        WRITE,
        ACKW,
        READ
    } state_t;

    localparam int ACK_CYCLES = 2;

    function automatic int frame_w(
        input int id_w,
        input int mem_aw,
        input int len_w
    );
        return id_w + mem_aw + len_w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slave_mem_burst_counter.sv
// Up-counter with synchronous clear; clear has priority over increment.
module slave_mem_burst_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         incr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (incr) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/slave_mem_burst.sv
// Serial-bus memory slave with ID match and auto-incrementing bursts.
import slave_pkg::*;

module slave_mem_burst #(
    parameter int                DATA_W   = 8,
    parameter int                MEM_AW   = 11,
    parameter int                ID_W     = 2,
    parameter int                LEN_W    = 3,
    parameter logic [ID_W-1:0]   SLAVE_ID = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AD_SEL,
    input  logic              B_RW,
    input  logic              B_BUS_OUT,
    output logic              B_BUS_IN,
    output logic              B_ACK,
    output logic              B_SBSY,
    output logic              B_READY,
    output logic              S_DVALID,
    output logic [DATA_W-1:0] S_DOUT
);

    localparam int A_W   = frame_w(ID_W, MEM_AW, LEN_W);
    localparam int CW    = max2($clog2(max2(A_W, DATA_W)), 1);
    localparam int BI    = max2($clog2(DATA_W), 1);
    localparam int DEPTH = 2 ** MEM_AW;

    state_t state;
    state_t nxt;

    logic [CW-1:0]     cnt;
    logic              cnt_clr;
    logic              cnt_inc;

    logic [A_W-2:0]    addr_sr;
    logic [A_W-1:0]    frame;
    logic [DATA_W-2:0] data_sr;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] rd_word;
    logic [LEN_W-1:0]  beats;
    logic [MEM_AW-1:0] ptr;
    logic              rw;

    logic last_addr;
    logic last_data;
    logic last_ack;
    logic id_hit;
    logic hdr_ld;
    logic adv;
    logic we;
    logic busy_state;

    logic [DATA_W-1:0] mem [DEPTH];

    slave_mem_burst_counter #(
        .W(CW)
    ) u_bit_cnt (
        .clk  (CLK),
        .rst  (RST | cnt_clr),
        .incr (cnt_inc),
        .count(cnt)
    );

    // Incoming bits shift in at the top, so after the last bit
    // the first-received (LSB) bit sits at index 0.
    assign frame = {B_BUS_OUT, addr_sr};
    assign word  = {B_BUS_OUT, data_sr};

    assign last_addr = (cnt == CW'(A_W - 1));
    assign last_data = (cnt == CW'(DATA_W - 1));
    assign last_ack  = (cnt == CW'(ACK_CYCLES - 1));
    assign id_hit    = (frame[ID_W-1:0] == SLAVE_ID);

    assign busy_state = (state != IDLE) && (state != IGNORE);

    always_comb begin
        nxt     = state;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        hdr_ld  = 1'b0;
        adv     = 1'b0;
        we      = 1'b0;

        unique case (state)
            IDLE: begin
                if (AD_SEL) begin
                    nxt = ADDR;
                end
            end
            ADDR: begin
                if (!last_addr) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end else begin
                    hdr_ld = id_hit;
                    nxt    = id_hit ? ACKA : IGNORE;
                end
            end
            IGNORE: begin
                if (!AD_SEL) begin
                    nxt = IDLE;
                end
            end
            ACKA: begin
                if (!last_ack) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end else begin
                    nxt = rw ? WRITE : READ;
                end
            end
            WRITE: begin
                if (!last_data) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end else begin
                    we  = 1'b1;
                    nxt = ACKW;
                end
            end
            ACKW: begin
                if (!last_ack) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end else begin
                    adv = 1'b1;
                    nxt = (beats == '0) ? IDLE : WRITE;
                end
            end
            READ: begin
                if (!last_data) begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                end else begin
                    adv = 1'b1;
                    if (beats == '0) begin
                        nxt = IDLE;
                    end
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase

        // Losing the grant drops any partial beat without side effects.
        if (!AD_SEL && busy_state) begin
            nxt     = IDLE;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
            hdr_ld  = 1'b0;
            adv     = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            addr_sr  <= '0;
            data_sr  <= '0;
            beats    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            B_ACK    <= 1'b0;
            B_SBSY   <= 1'b0;
            B_READY  <= 1'b0;
            S_DVALID <= 1'b0;
            S_DOUT   <= '0;
        end else begin
            state    <= nxt;
            B_READY  <= AD_SEL;
            B_ACK    <= (nxt == ACKA) || (nxt == ACKW);
            B_SBSY   <= (nxt != IDLE) && (nxt != IGNORE);
            S_DVALID <= we;

            if (state == ADDR) begin
                addr_sr <= frame[A_W-1:1];
            end
            if (state == WRITE) begin
                data_sr <= word[DATA_W-1:1];
            end
            if (we) begin
                S_DOUT <= word;
            end

            if (hdr_ld) begin
                rw    <= B_RW;
                ptr   <= frame[ID_W +: MEM_AW];
                beats <= frame[A_W-1 -: LEN_W];
            end else if (adv) begin
                ptr <= ptr + MEM_AW'(1);
                if (beats != '0) begin
                    beats <= beats - LEN_W'(1);
                end
            end
        end
    end

    // Array contents survive reset; only complete beats are committed.
    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            mem[ptr] <= word;
        end
    end

    assign rd_word  = mem[ptr];
    assign B_BUS_IN = (state == READ) & rd_word[cnt[BI-1:0]];

endmodule

// File: tb/tb_slave_mem_burst.sv
// Directed bench for slave_mem_burst with SLAVE_ID=2'b10.
module tb_slave_mem_burst;

    localparam int A_W = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       AD_SEL = 1'b0;
    logic       B_RW = 1'b0;
    logic       B_BUS_OUT = 1'b0;
    logic       B_BUS_IN;
    logic       B_ACK;
    logic       B_SBSY;
    logic       B_READY;
    logic       S_DVALID;
    logic [7:0] S_DOUT;

    int checks = 0;
    int errors = 0;

    slave_mem_burst #(
        .DATA_W  (8),
        .MEM_AW  (11),
        .ID_W    (2),
        .LEN_W   (3),
        .SLAVE_ID(2'b10)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .AD_SEL   (AD_SEL),
        .B_RW     (B_RW),
        .B_BUS_OUT(B_BUS_OUT),
        .B_BUS_IN (B_BUS_IN),
        .B_ACK    (B_ACK),
        .B_SBSY   (B_SBSY),
        .B_READY  (B_READY),
        .S_DVALID (S_DVALID),
        .S_DOUT   (S_DOUT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        AD_SEL = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_addr(input logic [1:0] id, input logic [10:0] addr,
                             input logic [2:0] len, input logic rw);
        logic [15:0] f;
        f = {len, addr, id};
        AD_SEL = 1'b1;
        tick();
        for (int i = 0; i < A_W; i++) begin
            B_BUS_OUT = f[i];
            B_RW = rw;
            tick();
        end
        B_BUS_OUT = 1'b0;
    endtask

    task automatic ack_phase(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (B_ACK !== 1'b1 || B_SBSY !== 1'b1 || B_READY !== 1'b1) begin
                errors++;
                $display("FAIL %s addr_ack%0d: ack=%b sbsy=%b rdy=%b, want 1 1 1",
                         tag, k, B_ACK, B_SBSY, B_READY);
            end
            tick();
        end
    endtask

    task automatic do_write(input string tag, input logic [1:0] id,
                            input logic [10:0] addr, input logic [2:0] len,
                            input logic [63:0] d);
        send_addr(id, addr, len, 1'b1);
        ack_phase(tag);
        for (int b = 0; b <= int'(len); b++) begin
            for (int i = 0; i < 8; i++) begin
                B_BUS_OUT = d[b*8+i];
                tick();
            end
            B_BUS_OUT = 1'b0;
            checks++;
            if (B_ACK !== 1'b1 || S_DVALID !== 1'b1 || S_DOUT !== d[b*8+:8]) begin
                errors++;
                $display("FAIL %s beat%0d ackw1: ack=%b dv=%b dout=%h, want 1 1 %h",
                         tag, b, B_ACK, S_DVALID, S_DOUT, d[b*8+:8]);
            end
            tick();
            checks++;
            if (B_ACK !== 1'b1 || S_DVALID !== 1'b0) begin
                errors++;
                $display("FAIL %s beat%0d ackw2: ack=%b dv=%b, want 1 0",
                         tag, b, B_ACK, S_DVALID);
            end
            tick();
        end
        checks++;
        if (B_ACK !== 1'b0 || B_SBSY !== 1'b0 || S_DVALID !== 1'b0) begin
            errors++;
            $display("FAIL %s end_idle: ack=%b sbsy=%b dv=%b, want 0 0 0",
                     tag, B_ACK, B_SBSY, S_DVALID);
        end
    endtask

    task automatic do_read(input string tag, input logic [10:0] addr,
                           input logic [2:0] len, input logic [63:0] exp_bits);
        send_addr(2'b10, addr, len, 1'b0);
        ack_phase(tag);
        for (int i = 0; i < (int'(len) + 1) * 8; i++) begin
            checks++;
            if (B_BUS_IN !== exp_bits[i] || B_SBSY !== 1'b1 || B_ACK !== 1'b0) begin
                errors++;
                $display("FAIL %s bit%0d: bus_in=%b sbsy=%b ack=%b, want %b 1 0",
                         tag, i, B_BUS_IN, B_SBSY, B_ACK, exp_bits[i]);
            end
            tick();
        end
        checks++;
        if (B_SBSY !== 1'b0 || B_BUS_IN !== 1'b0) begin
            errors++;
            $display("FAIL %s end_idle: sbsy=%b bus_in=%b, want 0 0",
                     tag, B_SBSY, B_BUS_IN);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        AD_SEL = 1'b1;
        tick();
        tick();
        checks++;
        if (B_ACK !== 1'b0 || B_SBSY !== 1'b0 || B_READY !== 1'b0 ||
            B_BUS_IN !== 1'b0 || S_DVALID !== 1'b0 || S_DOUT !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: ack=%b sbsy=%b rdy=%b bin=%b dv=%b dout=%h, want all 0",
                     B_ACK, B_SBSY, B_READY, B_BUS_IN, S_DVALID, S_DOUT);
        end
        RST = 1'b0;
        AD_SEL = 1'b0;
        tick();
        checks++;
        if (B_READY !== 1'b0 || B_SBSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b sbsy=%b, want 0 0", B_READY, B_SBSY);
        end
    endtask

    task automatic test_single_write();
        do_write("w_single", 2'b10, 11'h005, 3'd0, 64'hA5);
        idle(2);
        do_read("r_single", 11'h005, 3'd0, 64'hA5);
        idle(2);
    endtask

    task automatic test_burst_wrap();
        do_write("w_wrap", 2'b10, 11'h7FF, 3'd2, 64'h332211);
        idle(2);
        do_read("r_wrap", 11'h7FF, 3'd2, 64'h332211);
        idle(2);
        do_read("r_wrap_001", 11'h001, 3'd0, 64'h33);
        idle(2);
    endtask

    task automatic test_id_mismatch();
        send_addr(2'b01, 11'h005, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            B_BUS_OUT = 1'b1;
            checks++;
            if (B_ACK !== 1'b0 || B_SBSY !== 1'b0 || S_DVALID !== 1'b0 ||
                B_BUS_IN !== 1'b0) begin
                errors++;
                $display("FAIL idmis cyc%0d: ack=%b sbsy=%b dv=%b bin=%b, want 0 0 0 0",
                         i, B_ACK, B_SBSY, S_DVALID, B_BUS_IN);
            end
            tick();
        end
        B_BUS_OUT = 1'b0;
        idle(2);
        checks++;
        if (B_ACK !== 1'b0 || B_SBSY !== 1'b0 || B_READY !== 1'b0) begin
            errors++;
            $display("FAIL idmis_release: ack=%b sbsy=%b rdy=%b, want 0 0 0",
                     B_ACK, B_SBSY, B_READY);
        end
        do_read("r_idmis", 11'h005, 3'd0, 64'hA5);
        idle(2);
    endtask

    task automatic test_abort();
        do_write("w_pre_abort", 2'b10, 11'h010, 3'd0, 64'h5A);
        idle(2);
        send_addr(2'b10, 11'h010, 3'd0, 1'b1);
        ack_phase("abort");
        for (int i = 0; i < 4; i++) begin
            B_BUS_OUT = 1'b1;
            tick();
        end
        B_BUS_OUT = 1'b0;
        AD_SEL = 1'b0;
        tick();
        checks++;
        if (B_ACK !== 1'b0 || S_DVALID !== 1'b0 || B_SBSY !== 1'b0 ||
            B_READY !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: ack=%b dv=%b sbsy=%b rdy=%b, want 0 0 0 0",
                     B_ACK, S_DVALID, B_SBSY, B_READY);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (B_ACK !== 1'b0 || S_DVALID !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: ack=%b dv=%b, want 0 0",
                         i, B_ACK, S_DVALID);
            end
        end
        do_read("r_abort", 11'h010, 3'd0, 64'h5A);
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] exp_bits;
        exp_bits = 16'h2211;
        send_addr(2'b10, 11'h7FF, 3'd1, 1'b0);
        ack_phase("rst_read");
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (B_BUS_IN !== exp_bits[i]) begin
                errors++;
                $display("FAIL rst_read bit%0d: bus_in=%b, want %b",
                         i, B_BUS_IN, exp_bits[i]);
            end
            tick();
        end
        RST = 1'b1;
        tick();
        checks++;
        if (B_ACK !== 1'b0 || B_SBSY !== 1'b0 || B_READY !== 1'b0 ||
            B_BUS_IN !== 1'b0 || S_DVALID !== 1'b0 || S_DOUT !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outs: ack=%b sbsy=%b rdy=%b bin=%b dv=%b dout=%h, want all 0",
                     B_ACK, B_SBSY, B_READY, B_BUS_IN, S_DVALID, S_DOUT);
        end
        RST = 1'b0;
        idle(1);
        do_read("r_after_rst", 11'h000, 3'd0, 64'h22);
        idle(2);
    endtask

    task automatic test_back_to_back();
        do_write("w_b2b_1", 2'b10, 11'h020, 3'd0, 64'h3C);
        do_write("w_b2b_2", 2'b10, 11'h021, 3'd0, 64'hC3);
        idle(2);
        do_read("r_b2b", 11'h020, 3'd1, 64'hC33C);
        idle(2);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_id_mismatch();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
